// File: rtl/sum_stream_serializer.sv
// Buffers nibble-adder sums in a small FIFO and sends each one as a UART-style
// frame: start bit, data bits LSB first, even parity, stop bit.
module sum_stream_serializer #(
  parameter int DATA_W       = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            in_ready,
  input  logic                            clear_ovf,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, drop;
  state_e            state_q;

  assign in_ready = (cnt_q != FULL);
  assign push     = in_valid & in_ready;
  // Drop decision uses the registered full state, so a same-cycle pop does not rescue the word.
  assign drop     = in_valid & ~in_ready;
  assign pop      = (state_q == IDLE) & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear_ovf) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // ---------------------------------------------------------- serializer
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [TW-1:0]     tick_q;
  logic [BW-1:0]     bit_q;
  logic              tx_q, busy_q;
  logic [DATA_W-1:0] head;

  assign head = mem_q[rd_ptr_q];

  // tx_q is loaded with the next bit on every transition so the line is a clean flop output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      tick_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tick_q <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (pop) begin
            shift_q <= head;
            par_q   <= ^head;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick_q == TLAST) begin
            tick_q  <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_q == TLAST) begin
            tick_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == BLAST) begin
              bit_q   <= '0;
              state_q <= PARITY;
              tx_q    <= par_q;
            end else begin
              bit_q <= bit_q + BW'(1);
              tx_q  <= shift_q[1];
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        PARITY: begin
          if (tick_q == TLAST) begin
            tick_q  <= '0;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_q == TLAST) begin
            tick_q  <= '0;
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tick_q  <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sum_stream_serializer.sv
// Directed bench for sum_stream_serializer at default parameters: frame shape,
// back-to-back spacing, FIFO full/drop, sticky overflow and async reset.
module tb_sum_stream_serializer;

  logic       clk = 1'b0;
  logic       reset, in_valid, clear_ovf;
  logic [3:0] in_data;
  logic       in_ready, tx, busy, overflow;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  sum_stream_serializer #(.DATA_W(4), .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clear_ovf(clear_ovf), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_tx"}, tx, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // bits[i] is the i-th transmitted bit (start first, stop last), 4 cycles each.
  task automatic frame(input string tag, input logic [6:0] bits, input int skip);
    for (int k = skip; k < 28; k++) begin
      chk({tag, "_tx"}, tx, bits[k/4]);
      chk({tag, "_busy"}, busy, 1);
      step();
    end
  endtask

  initial begin
    logic [6:0] exp_bits [1:5];
    exp_bits[1] = 7'b1100010;
    exp_bits[2] = 7'b1100100;
    exp_bits[3] = 7'b1000110;
    exp_bits[4] = 7'b1101000;
    exp_bits[5] = 7'b1001010;

    reset = 1'b1; in_valid = 1'b0; clear_ovf = 1'b0; in_data = 4'h0;
    #2;
    idle_chk("rst");
    chk("rst_cnt", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rdy", in_ready, 1);
    step(); step();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      idle_chk("idle");
      chk("idle_cnt", fifo_count, 0);
      chk("idle_ovf", overflow, 0);
      chk("idle_rdy", in_ready, 1);
      step();
    end

    // Single word 0xA: pop one cycle after push, tx falls the cycle after that.
    push(4'hA);
    idle_chk("a_pre");
    chk("a_cnt1", fifo_count, 1);
    step();
    frame("fA", 7'b1010100, 0);
    idle_chk("a_post");
    chk("a_cnt", fifo_count, 0);

    // 0x7 then 0x0 back-to-back with one idle cycle between them.
    push(4'h7);
    push(4'h0);
    frame("f7", 7'b1101110, 0);
    idle_chk("gap70");
    step();
    frame("f0", 7'b1000000, 0);
    idle_chk("post0");

    // Six consecutive pushes: fifth fills the FIFO, sixth is dropped.
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i);
      chk("fill_rdy", in_ready, (i < 6) ? 1 : 0);
      if (i == 6) chk("fill_peak", fifo_count, 4);
      step();
    end
    in_valid = 1'b0;
    chk("drop_ovf", overflow, 1);
    chk("drop_cnt", fifo_count, 4);
    frame("q1", exp_bits[1], 4);
    for (int w = 2; w <= 5; w++) begin
      idle_chk("qgap");
      step();
      frame("qw", exp_bits[w], 0);
    end
    idle_chk("q_end");
    chk("q_cnt", fifo_count, 0);
    chk("q_ovf_sticky", overflow, 1);

    // clear_ovf alone clears; coincident with a drop the set wins.
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 8);
      if (i == 5) clear_ovf = 1'b1;
      step();
    end
    in_valid  = 1'b0;
    clear_ovf = 1'b0;
    chk("clr_vs_drop", overflow, 1);

    // Mid-frame async reset with three words queued.
    reset = 1'b1;
    #2;
    idle_chk("rst2");
    step();
    reset = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    step(); step(); step(); step();
    chk("mid_cnt", fifo_count, 3);
    chk("mid_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    idle_chk("async");
    chk("async_cnt", fifo_count, 0);
    chk("async_rdy", in_ready, 1);
    chk("async_ovf", overflow, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      idle_chk("post_rst");
      chk("post_rst_cnt", fifo_count, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_stream_serializer.md
Name: sum_stream_serializer

Overview:
Downstream consumer of the registered 4-bit nibble-adder result stream. It buffers accepted sums in a small FIFO. Each sum is then sent on a single-wire, UART-style serial line: start bit, data bits LSB first, even parity, stop bit. Status outputs (busy, fill level, sticky overflow) are intended for spare output pins.

Parameters:
DATA_W, 4, width of each sum word
FIFO_DEPTH, 4, number of buffered words (power of two, >=2)
CLKS_PER_BIT, 4, clk cycles each serial bit is held (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  sum word present this cycle
in_data  input  DATA_W  sum word
in_ready  output  1  FIFO not full
clear_ovf  input  1  synchronous clear of overflow flag
tx  output  1  serial line, idle high
busy  output  1  frame in progress
fifo_count  output  $clog2(FIFO_DEPTH+1)  words held, 0..FIFO_DEPTH
overflow  output  1  sticky: a word was dropped

Behaviour:
- Reset (async, active-high, mid-frame included): tx=1, busy=0, fifo_count=0, overflow=0, in_ready=1. FSM goes to IDLE. Shift register, bit counter and tick counter clear. FIFO contents are discarded. No partial frame resumes after reset.
- Clocking: all state updates on posedge clk. All outputs are registered or decoded from registered state.
- in_ready is combinational from fifo_count: in_ready = (fifo_count != FIFO_DEPTH).
- Push: in_valid && in_ready writes in_data at the write pointer. The pointer wraps modulo FIFO_DEPTH.
- Drop: in_valid && !in_ready discards the word and sets overflow=1. The drop is based on the registered full state, even if a pop occurs in the same cycle.
- Overflow flag: stays 1 until reset or clear_ovf. If clear_ovf and a drop occur in the same cycle, the set wins.
- Simultaneous push+pop (FIFO not full): both take effect and fifo_count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0. If fifo_count!=0, pop the head word into the shift register, compute parity = XOR of its bits, and go to START. A word pushed into an empty FIFO is popped on the following cycle, not the same cycle.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0]; after CLKS_PER_BIT cycles, shift right. After DATA_W bits go to PARITY.
- PARITY: tx=parity (even parity: total of ones in data+parity is even) for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- busy=1 in every state except IDLE.
- Frame length is (DATA_W+3)*CLKS_PER_BIT cycles, i.e. 28 at defaults. There is a minimum 1-cycle IDLE gap between back-to-back frames.
- Latency: push at cycle 0 into an empty FIFO with FSM in IDLE gives a pop at cycle 1 and tx falling at cycle 2.
- Tick counter counts 0..CLKS_PER_BIT-1 and resets on each state/bit change. With CLKS_PER_BIT=1 every bit lasts exactly one cycle.
- The block never raises X on tx. Upper unused count bits are 0.

Test Plan:
- Reset then idle 20 cycles -> tx=1, busy=0, fifo_count=0, overflow=0, in_ready=1 throughout.
- Push 4'hA once -> tx sequence 0,0,1,0,1,0,1, each held 4 cycles. Tx falls 2 cycles after the push; busy is high 28 cycles, then tx=1, busy=0.
- Push 4'h7 -> data bits 1,1,1,0 and parity bit 1. Push 4'h0 -> parity 0. Both frames sent back-to-back with exactly one idle cycle between stop and next start.
- Push 6 words on consecutive cycles 0..5 from empty/idle (values 1..6) -> words 1..5 accepted (count peaks at 4, in_ready=0 at cycle 5) and word 6 dropped. overflow=1 and stays set. Frames carry 1,2,3,4,5 in order.
- With overflow=1, assert clear_ovf one cycle -> overflow=0. Clear_ovf coincident with a drop -> overflow stays 1.
- Assert reset in the middle of the DATA state of a frame with 3 words queued -> tx=1, busy=0, fifo_count=0 immediately (async). After release, no frame is sent until a new push.
